// File: rtl/huff_bit_packer_pkg.sv
// Shared JPEG entropy-coding constants, FSM state type and helpers for the Huffman bit packer.
package huff_bit_packer_pkg;

  localparam int unsigned HUFF_MAX_CODE_W = 32;
  localparam int unsigned HUFF_ACC_W      = 64;

  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic       JPEG_PAD_BIT       = 1'b1;

  typedef enum logic [1:0] {
    StRun,
    StStuff,
    StFlush,
    StDone
  } huff_state_e;

  function automatic logic [5:0] clamp_len(input logic [5:0] len, input logic [5:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/huff_bit_acc.sv
// MSB-first bit accumulator: optional shift-out of the top byte, then append or pad-to-byte.
module huff_bit_acc
  import huff_bit_packer_pkg::*;
#(
  parameter int unsigned MAX_CODE_W = HUFF_MAX_CODE_W,
  parameter int unsigned ACC_W      = HUFF_ACC_W,
  localparam int unsigned FillW     = $clog2(ACC_W + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic                  append_i,
  input  logic [MAX_CODE_W-1:0] code_i,
  input  logic [5:0]            len_i,
  input  logic                  pad_i,
  output logic [7:0]            top_byte_o,
  output logic [FillW-1:0]      fill_o,
  output logic [FillW-1:0]      fill_next_o
);

  logic [ACC_W-1:0]      acc_q, acc_d, acc_s, code_ext, pad_mask;
  logic [FillW-1:0]      fill_q, fill_d, fill_s, fill_up;
  logic [MAX_CODE_W-1:0] code_mask;
  logic [5:0]            len_c;

  always_comb begin
    len_c     = clamp_len(len_i, 6'(MAX_CODE_W));
    code_mask = ~({MAX_CODE_W{1'b1}} << len_c);
    code_ext  = ACC_W'(code_i & code_mask);

    // The outgoing byte leaves first; append and padding act on what remains.
    acc_s  = shift_i ? (acc_q << 8) : acc_q;
    fill_s = shift_i ? (fill_q - FillW'(8)) : fill_q;

    fill_up  = (fill_s + FillW'(7)) & ~FillW'(7);
    pad_mask = ({ACC_W{1'b1}} >> fill_s) & ~({ACC_W{1'b1}} >> fill_up);

    acc_d  = acc_s;
    fill_d = fill_s;
    if (append_i) begin
      acc_d  = acc_s | (code_ext << (FillW'(ACC_W) - fill_s - FillW'(len_c)));
      fill_d = fill_s + FillW'(len_c);
    end else if (pad_i && (|fill_s[2:0])) begin
      acc_d  = (acc_s & ~pad_mask) | ({ACC_W{JPEG_PAD_BIT}} & pad_mask);
      fill_d = fill_up;
    end

    if (clear_i) begin
      acc_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign top_byte_o  = acc_q[ACC_W-1 -: 8];
  assign fill_o      = fill_q;
  assign fill_next_o = fill_d;

endmodule

// File: rtl/huff_bit_packer.sv
// Huffman codeword to JPEG byte-stream packer with 0xFF/0x00 stuffing and 1-padded flush.
// Optional byte counter output enabled by defining HUFF_BYTE_CNT_EN.
module huff_bit_packer
  import huff_bit_packer_pkg::*;
#(
  parameter int unsigned MAX_CODE_W = HUFF_MAX_CODE_W,
  parameter int unsigned ACC_W      = HUFF_ACC_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [MAX_CODE_W-1:0] in_code_i,
  input  logic [5:0]            in_len_i,
  input  logic                  in_flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [7:0]            out_byte_o,
  output logic                  flush_done_o
`ifdef HUFF_BYTE_CNT_EN
  ,
  output logic [31:0]           byte_cnt_o
`endif
);

  localparam int unsigned FillW = $clog2(ACC_W + 1);

  huff_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, flush_done_q;
  logic             flush_pend_q, flush_pend_d;
  logic [7:0]       out_byte_q;
  logic [7:0]       top_byte;
  logic [FillW-1:0] fill, fill_next;
  logic             in_fire, out_acc, out_free, stuff_now, load, done_now;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_acc  = out_valid_q & out_ready_i;
  assign out_free = ~out_valid_q | out_acc;
  // A marker byte leaving the output register forces the stuff byte into the next slot.
  assign stuff_now = out_acc & (state_q != StStuff) & (out_byte_q == JPEG_MARKER_PREFIX);
  assign load      = out_free & ~stuff_now & (fill >= FillW'(8)) &
                     ((state_q == StRun) | (state_q == StFlush));
  assign done_now  = (state_q == StFlush) & (fill == '0) & out_free & ~stuff_now;

  huff_bit_acc #(
    .MAX_CODE_W(MAX_CODE_W),
    .ACC_W     (ACC_W)
  ) u_acc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (state_q == StDone),
    .shift_i    (load),
    .append_i   (in_fire),
    .code_i     (in_code_i),
    .len_i      (in_len_i),
    .pad_i      (state_q == StFlush),
    .top_byte_o (top_byte),
    .fill_o     (fill),
    .fill_next_o(fill_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (stuff_now) begin
          state_d = StStuff;
        end else if (in_fire & in_flush_i) begin
          state_d = StFlush;
        end
      end
      StStuff: begin
        if (out_acc) begin
          state_d = flush_pend_q ? StFlush : StRun;
        end
      end
      StFlush: begin
        if (stuff_now) begin
          state_d = StStuff;
        end else if (done_now) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase

    flush_pend_d = (flush_pend_q | (in_fire & in_flush_i)) & (state_q != StDone);
    in_ready_d   = (state_d == StRun) & ((32'(fill_next) + MAX_CODE_W) <= ACC_W);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= '0;
      flush_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      flush_done_q <= (state_d == StDone);
      flush_pend_q <= flush_pend_d;
      if (stuff_now) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= JPEG_STUFF_BYTE;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= top_byte;
      end else if (out_acc) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_byte_o   = out_byte_q;
  assign flush_done_o = flush_done_q;

`ifdef HUFF_BYTE_CNT_EN
  logic [31:0] byte_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
    end else if (flush_done_q) begin
      byte_cnt_q <= '0;
    end else if (out_acc && (byte_cnt_q != '1)) begin
      byte_cnt_q <= byte_cnt_q + 32'd1;
    end
  end

  assign byte_cnt_o = byte_cnt_q;
`endif

endmodule
